// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker: self-synchronises, locks, counts bit errors.
// Define PRBS31_BITCNT_EN to add the 32-bit bit_count output (valid bits checked in LOCKED).
module prbs31_checker #(
    parameter int ERR_W       = 16,
    parameter int LOCK_GOOD   = 64,
    parameter int LOSS_WINDOW = 256,
    parameter int LOSS_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             rx_valid,
    input  logic             rx_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state_o
`ifdef PRBS31_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int WIN_W  = $clog2(LOSS_WINDOW + 1);
    localparam int WERR_W = $clog2(LOSS_THRESH + 1);

    state_e              state_q, state_d;
    logic [30:0]         s_q, s_d;
    logic [4:0]          fill_q, fill_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [WERR_W-1:0]   werr_q, werr_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic                err_pulse_q, err_pulse_d;
    logic                locked_q, locked_d;
`ifdef PRBS31_BITCNT_EN
    logic [31:0]         bc_q, bc_d;
`endif

    logic pred;
    logic mismatch;
    logic take;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        good_d      = good_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
`ifdef PRBS31_BITCNT_EN
        bc_d        = bc_q;
`endif
        pred     = s_q[30] ^ s_q[27];
        mismatch = rx_bit ^ pred;
        take     = ena & rx_valid;

        if (take) begin
            unique case (state_q)
                ST_SEARCH: begin
                    s_d = {s_q[29:0], rx_bit};
                    if (fill_q == 5'd30) begin
                        // An all-zero register is the LFSR lock-up state; refill instead.
                        fill_d = '0;
                        if (s_d != '0) begin
                            state_d = ST_VERIFY;
                            good_d  = '0;
                        end
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                ST_VERIFY: begin
                    s_d = {s_q[29:0], rx_bit};
                    if (mismatch) begin
                        state_d = ST_SEARCH;
                        fill_d  = '0;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                        if (good_d == GOOD_W'(LOCK_GOOD)) begin
                            state_d = ST_LOCKED;
                            win_d   = '0;
                            werr_d  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Free-running local reference so a line error is counted only once.
                    s_d         = {s_q[29:0], pred};
                    err_pulse_d = mismatch;
                    win_d       = win_q + 1'b1;
                    werr_d      = werr_q + WERR_W'(mismatch);
                    if (mismatch && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
`ifdef PRBS31_BITCNT_EN
                    bc_d = bc_q + 32'd1;
`endif
                    if (werr_d == WERR_W'(LOSS_THRESH)) begin
                        state_d = ST_SEARCH;
                        fill_d  = '0;
                        good_d  = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_d == WIN_W'(LOSS_WINDOW)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end

        if (ena && clear) begin
            err_cnt_d = '0;
            win_d     = '0;
            werr_d    = '0;
`ifdef PRBS31_BITCNT_EN
            bc_d      = '0;
`endif
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEARCH;
            s_q         <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
`ifdef PRBS31_BITCNT_EN
            bc_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
`ifdef PRBS31_BITCNT_EN
            bc_q        <= bc_d;
`endif
        end
    end

    assign state_o   = state_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
`ifdef PRBS31_BITCNT_EN
    assign bit_count = bc_q;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: table of stream phases from a seeded PRBS31 source,
// plus hand-written reset, all-zero and VERIFY-mismatch sequences.
module tb_prbs31_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        clear;
    logic        rx_valid;
    logic        rx_bit;
    logic        locked, sat_locked;
    logic        err_pulse, sat_err_pulse;
    logic [15:0] err_count;
    logic [3:0]  sat_err_count;
    logic [1:0]  state_o, sat_state_o;
`ifdef PRBS31_BITCNT_EN
    logic [31:0] bit_count, sat_bit_count;
`endif

    always #5 clk = ~clk;

    prbs31_checker u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clear     (clear),
        .rx_valid  (rx_valid),
        .rx_bit    (rx_bit),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state_o   (state_o)
`ifdef PRBS31_BITCNT_EN
        ,
        .bit_count (bit_count)
`endif
    );

    // Narrow-counter instance fed the same stream, for saturation.
    prbs31_checker #(.ERR_W(4)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clear     (clear),
        .rx_valid  (rx_valid),
        .rx_bit    (rx_bit),
        .locked    (sat_locked),
        .err_pulse (sat_err_pulse),
        .err_count (sat_err_count),
        .state_o   (sat_state_o)
`ifdef PRBS31_BITCNT_EN
        ,
        .bit_count (sat_bit_count)
`endif
    );

    typedef struct {
        string    name;
        int       nbits;
        bit       en;
        bit       gap;
        int       flip_period;
        int       flip_cnt;
        bit       clr_last;
        bit [1:0] exp_state;
        bit       exp_locked;
        int       exp_err;
        int       exp_pulses;
        int       exp_bc;
    } vec_t;

    localparam logic [30:0] SEED = 31'h7FFF_FFFF;

    int          checks = 0;
    int          errors = 0;
    int          pulse_cnt;
    logic [30:0] g;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; also tallies err_pulse produced by the previous edge.
    task automatic cycle(input logic en, input logic vld, input logic flp, input logic clr);
        logic b;
        @(negedge clk);
        pulse_cnt += int'(err_pulse);
        b        = g[30] ^ g[27];
        ena      = en;
        rx_valid = vld;
        clear    = clr;
        rx_bit   = b ^ flp;
        if (vld && en) g = {g[29:0], b};
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0; ena = 1'b0; clear = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0;
        g = SEED;
        pulse_cnt = 0;

        //            name        nbits  en gap per cnt clr  st     lk  err pul bc
        vecs.push_back('{"fill30",   30,    1, 0,  0,  0, 0, 2'b00, 0,  0,  0, 0});
        vecs.push_back('{"bit31",    1,     1, 0,  0,  0, 0, 2'b01, 0,  0,  0, 0});
        vecs.push_back('{"verify63", 63,    1, 0,  0,  0, 0, 2'b01, 0,  0,  0, 0});
        vecs.push_back('{"bit95",    1,     1, 0,  0,  0, 0, 2'b10, 1,  0,  0, 0});
        vecs.push_back('{"clean",    10000, 1, 0,  0,  0, 0, 2'b10, 1,  0,  0, 10000});
        vecs.push_back('{"single",   32,    1, 0,  1,  1, 0, 2'b10, 1,  1,  1, 10032});
        vecs.push_back('{"gaps",     100,   1, 1,  0,  0, 0, 2'b10, 1,  1,  0, 10132});
        vecs.push_back('{"ena_low",  20,    0, 0,  1, 20, 0, 2'b10, 1,  1,  0, 10132});
        vecs.push_back('{"clr_err",  1,     1, 0,  1,  1, 1, 2'b10, 1,  0,  1, 0});
        vecs.push_back('{"loss7",    84,    1, 0, 12,  7, 0, 2'b10, 1,  7,  7, 84});
        vecs.push_back('{"loss8",    12,    1, 0, 12,  1, 0, 2'b00, 0,  8,  1, 96});
        vecs.push_back('{"relock",   95,    1, 0,  0,  0, 0, 2'b10, 1,  8,  0, 96});
        vecs.push_back('{"spread14", 512,   1, 0, 36, 14, 0, 2'b10, 1, 22, 14, 608});

        repeat (2) @(negedge clk);
        check("rst_state", state_o, 0);
        check("rst_locked", locked, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_pulse", err_pulse, 0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            int  nflip;
            logic flp;
            nflip     = 0;
            pulse_cnt = 0;
            for (int i = 0; i < vecs[k].nbits; i++) begin
                flp = (vecs[k].flip_period != 0) &&
                      ((i % vecs[k].flip_period) == vecs[k].flip_period - 1) &&
                      (nflip < vecs[k].flip_cnt);
                if (flp) nflip++;
                cycle(vecs[k].en, 1'b1, flp, vecs[k].clr_last && (i == vecs[k].nbits - 1));
                if (vecs[k].gap) cycle(1'b1, 1'b0, 1'b1, 1'b0);
            end
            idle();
            check({vecs[k].name, "_state"}, state_o, vecs[k].exp_state);
            check({vecs[k].name, "_locked"}, locked, vecs[k].exp_locked);
            check({vecs[k].name, "_err_count"}, err_count, vecs[k].exp_err);
            check({vecs[k].name, "_pulses"}, pulse_cnt, vecs[k].exp_pulses);
            check({vecs[k].name, "_sat_count"}, sat_err_count,
                  (vecs[k].exp_err > 15) ? 15 : vecs[k].exp_err);
`ifdef PRBS31_BITCNT_EN
            check({vecs[k].name, "_bit_count"}, bit_count, vecs[k].exp_bc);
`endif
            $display("step %-9s state=%0d locked=%0d err_count=%0d pulses=%0d sat=%0d",
                     vecs[k].name, state_o, locked, err_count, pulse_cnt, sat_err_count);
        end

        // Asynchronous reset while LOCKED: outputs clear without a clock edge.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_state", state_o, 0);
        check("arst_locked", locked, 0);
        check("arst_err_count", err_count, 0);
        check("arst_sat_count", sat_err_count, 0);
        check("arst_err_pulse", err_pulse, 0);
`ifdef PRBS31_BITCNT_EN
        check("arst_bit_count", bit_count, 0);
`endif
        $display("seq async_reset state=%0d locked=%0d err_count=%0d", state_o, locked, err_count);
        @(negedge clk);
        rst_n = 1'b1;
        g = SEED;

        // 200 zero bits never leave SEARCH.
        pulse_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            pulse_cnt += int'(err_pulse);
            ena = 1'b1; rx_valid = 1'b1; clear = 1'b0; rx_bit = 1'b0;
        end
        idle();
        check("zeros_state", state_o, 0);
        check("zeros_locked", locked, 0);
        check("zeros_err_count", err_count, 0);
        check("zeros_pulses", pulse_cnt, 0);
        $display("seq zeros200 state=%0d locked=%0d err_count=%0d", state_o, locked, err_count);

        // VERIFY mismatch on bit 40 drops back to SEARCH.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        g = SEED;
        for (int i = 0; i < 39; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        check("vmis_bit39_state", state_o, 1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        check("vmis_bit40_state", state_o, 0);
        check("vmis_bit40_locked", locked, 0);
        check("vmis_err_count", err_count, 0);
        $display("seq verify_mismatch state=%0d locked=%0d", state_o, locked);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
